// File: rtl/rx_loop.sv
`default_nettype none
// ============================================================================
// Module   : rx_loop
// Purpose  : Receive-side loopback checker. Consumes the per-frame byte
//            stream of the looping transmitter test application (length=6,
//            4-byte little-endian sequence number, 2-byte FCS), validates
//            each frame, tracks the sequence number and keeps saturating
//            good / lost / error statistics.
// Macro    : RX_LOOP_CONF_FCS_CHECK_EN - when defined, a frame whose FCS
//            verdict is bad at i_end is rejected; otherwise i_fcs_ok is
//            ignored.
// Ports    : clk, reset (async, active-high)
//            i_sfd, i_byte_valid, i_byte[7:0], i_end, i_fcs_ok  - rx stream
//            o_sync, o_frm_ok, o_frm_err                        - status
//            o_last_seq, o_rx_cnt, o_lost_cnt, o_err_cnt [31:0] - statistics
// Revision : 1.0 - initial release
// ============================================================================
module rx_loop #(
  parameter logic [31:0] TIMEOUT_CNT = 32'd2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_sfd,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  input  logic        i_end,
  input  logic        i_fcs_ok,
  output logic        o_sync,
  output logic        o_frm_ok,
  output logic        o_frm_err,
  output logic [31:0] o_last_seq,
  output logic [31:0] o_rx_cnt,
  output logic [31:0] o_lost_cnt,
  output logic [31:0] o_err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0]  c_len_byte = 8'd6;
  localparam logic [2:0]  c_idx_full = 3'd7;   // 7 bytes received
  localparam logic [31:0] c_ones     = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == c_ones) ? v : v + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] tmo_q, tmo_d;
  logic        bad_q, bad_d;
  logic [31:0] seq_q, seq_d;
  logic [31:0] exp_q, exp_d;
  logic        sync_q, sync_d;
  logic [31:0] last_seq_q, last_seq_d;
  logic [31:0] rx_cnt_q, rx_cnt_d;
  logic [31:0] lost_cnt_q, lost_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;
  logic        frm_ok_q, frm_ok_d;
  logic        frm_err_q, frm_err_d;

  logic        w_fcs_bad;
  logic [31:0] w_gap;
  logic [32:0] w_lost_sum;
  logic        w_tmo_hit;

  // Frames skipped between the expected and the received sequence number;
  // the 33-bit sum exposes the carry used for saturation.
  assign w_gap      = seq_q - exp_q;
  assign w_lost_sum = {1'b0, lost_cnt_q} + {1'b0, w_gap};
  assign w_tmo_hit  = ({1'b0, tmo_q} + 33'd1) >= {1'b0, TIMEOUT_CNT};

`ifdef RX_LOOP_CONF_FCS_CHECK_EN
  logic fcs_ok_q, fcs_ok_d;

  always_comb begin
    fcs_ok_d = fcs_ok_q;
    if (state_q == RECV && !i_sfd && i_end) fcs_ok_d = i_fcs_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcs_ok_q <= 1'b0;
    else       fcs_ok_q <= fcs_ok_d;
  end

  assign w_fcs_bad = ~fcs_ok_q;
`else
  // FCS path not trusted during bring-up: verdict deliberately ignored.
  logic w_unused_fcs_ok;
  assign w_unused_fcs_ok = i_fcs_ok;
  assign w_fcs_bad       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    bad_d      = bad_q;
    seq_d      = seq_q;
    exp_d      = exp_q;
    sync_d     = sync_q;
    last_seq_d = last_seq_q;
    rx_cnt_d   = rx_cnt_q;
    lost_cnt_d = lost_cnt_q;
    err_cnt_d  = err_cnt_q;
    frm_ok_d   = 1'b0;
    frm_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_sfd) begin
          state_d = RECV;
          idx_d   = 3'd0;
          tmo_d   = 32'd0;
          bad_d   = 1'b0;
        end
      end

      RECV: begin
        if (i_sfd) begin
          // New delimiter inside a frame: drop it and start over.
          frm_err_d = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
          idx_d     = 3'd0;
          tmo_d     = 32'd0;
          bad_d     = 1'b0;
        end else if (i_end) begin
          state_d = CHECK;
        end else if (i_byte_valid) begin
          tmo_d = 32'd0;
          case (idx_q)
            3'd0:    if (i_byte != c_len_byte) bad_d = 1'b1;
            3'd1:    seq_d[7:0]   = i_byte;
            3'd2:    seq_d[15:8]  = i_byte;
            3'd3:    seq_d[23:16] = i_byte;
            3'd4:    seq_d[31:24] = i_byte;
            3'd7:    bad_d = 1'b1;          // overlong frame
            default: ;                      // FCS bytes: counted only
          endcase
          if (idx_q != c_idx_full) idx_d = idx_q + 3'd1;
        end else if (w_tmo_hit) begin
          frm_err_d = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      CHECK: begin
        if (bad_q || (idx_q != c_idx_full) || w_fcs_bad) begin
          frm_err_d = 1'b1;
          err_cnt_d = sat_inc(err_cnt_q);
        end else if (sync_q && (seq_q < exp_q)) begin
          // Out-of-order: reject but resynchronise on the received number.
          frm_err_d  = 1'b1;
          err_cnt_d  = sat_inc(err_cnt_q);
          last_seq_d = seq_q;
          exp_d      = seq_q + 32'd1;
        end else begin
          if (sync_q && (seq_q > exp_q))
            lost_cnt_d = w_lost_sum[32] ? c_ones : w_lost_sum[31:0];
          frm_ok_d   = 1'b1;
          sync_d     = 1'b1;
          rx_cnt_d   = sat_inc(rx_cnt_q);
          last_seq_d = seq_q;
          exp_d      = seq_q + 32'd1;   // wraps naturally at all-ones
        end

        if (i_sfd) begin
          state_d = RECV;
          idx_d   = 3'd0;
          tmo_d   = 32'd0;
          bad_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      tmo_q      <= 32'd0;
      bad_q      <= 1'b0;
      seq_q      <= 32'd0;
      exp_q      <= 32'd0;
      sync_q     <= 1'b0;
      last_seq_q <= 32'd0;
      rx_cnt_q   <= 32'd0;
      lost_cnt_q <= 32'd0;
      err_cnt_q  <= 32'd0;
      frm_ok_q   <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      bad_q      <= bad_d;
      seq_q      <= seq_d;
      exp_q      <= exp_d;
      sync_q     <= sync_d;
      last_seq_q <= last_seq_d;
      rx_cnt_q   <= rx_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      err_cnt_q  <= err_cnt_d;
      frm_ok_q   <= frm_ok_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign o_sync     = sync_q;
  assign o_frm_ok   = frm_ok_q;
  assign o_frm_err  = frm_err_q;
  assign o_last_seq = last_seq_q;
  assign o_rx_cnt   = rx_cnt_q;
  assign o_lost_cnt = lost_cnt_q;
  assign o_err_cnt  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_loop.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_loop
// Purpose  : Directed self-checking bench for rx_loop. One task per scenario,
//            expected values hand-computed from the frame sequences driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_loop;

  localparam logic [31:0] TMO = 32'd40;

`ifdef RX_LOOP_CONF_FCS_CHECK_EN
  localparam bit FCS_EN = 1'b1;
`else
  localparam bit FCS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_sfd = 1'b0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte = 8'd0;
  logic        i_end = 1'b0;
  logic        i_fcs_ok = 1'b1;
  logic        o_sync, o_frm_ok, o_frm_err;
  logic [31:0] o_last_seq, o_rx_cnt, o_lost_cnt, o_err_cnt;

  int n_pass = 0;
  int n_total = 0;
  int n_ok = 0;
  int n_err = 0;

  rx_loop #(.TIMEOUT_CNT(TMO)) dut (
    .clk(clk), .reset(reset), .i_sfd(i_sfd), .i_byte_valid(i_byte_valid),
    .i_byte(i_byte), .i_end(i_end), .i_fcs_ok(i_fcs_ok),
    .o_sync(o_sync), .o_frm_ok(o_frm_ok), .o_frm_err(o_frm_err),
    .o_last_seq(o_last_seq), .o_rx_cnt(o_rx_cnt), .o_lost_cnt(o_lost_cnt),
    .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle; ok and err must never coincide.
  always @(negedge clk) begin
    if (o_frm_ok)  n_ok++;
    if (o_frm_err) n_err++;
    if (o_frm_ok && o_frm_err) begin
      n_total++;
      $display("FAIL pulse_exclusive: ok=1 err=1, required at most one high");
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    i_sfd = 0; i_byte_valid = 0; i_end = 0; i_fcs_ok = 1;
    reset = 1; tick(); tick();
    reset = 0; tick();
  endtask

  task automatic pulse_sfd();
    i_sfd = 1; tick(); i_sfd = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte_valid = 1; i_byte = b; tick();
    i_byte_valid = 0; tick();
  endtask

  task automatic send_body(input logic [7:0] len, input logic [31:0] seq, input int n);
    logic [7:0] b [7];
    b[0] = len; b[1] = seq[7:0]; b[2] = seq[15:8]; b[3] = seq[23:16];
    b[4] = seq[31:24]; b[5] = 8'hC3; b[6] = 8'h3C;
    for (int i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic end_frame(input logic fcs);
    i_end = 1; i_fcs_ok = fcs; tick();
    i_end = 0; i_fcs_ok = 1;
  endtask

  task automatic frame(input logic [7:0] len, input logic [31:0] seq, input int n, input logic fcs);
    pulse_sfd();
    send_body(len, seq, n);
    end_frame(fcs);
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (o_sync !== 1'b0) $display("FAIL reset_sync: got %0b want 0", o_sync); else n_pass++;
    n_total++; if (o_frm_ok !== 1'b0 || o_frm_err !== 1'b0) $display("FAIL reset_pulses: got ok=%0b err=%0b want 0", o_frm_ok, o_frm_err); else n_pass++;
    n_total++; if (o_last_seq !== 32'd0) $display("FAIL reset_last_seq: got %0h want 0", o_last_seq); else n_pass++;
    n_total++; if (o_rx_cnt !== 32'd0 || o_lost_cnt !== 32'd0 || o_err_cnt !== 32'd0)
      $display("FAIL reset_counters: got rx=%0d lost=%0d err=%0d want 0", o_rx_cnt, o_lost_cnt, o_err_cnt); else n_pass++;
  endtask

  task automatic test_in_order();
    int ok0;
    do_reset();
    ok0 = n_ok;
    pulse_sfd();
    send_body(8'd6, 32'd0, 7);
    i_end = 1; tick(); i_end = 0;       // CHECK cycle now
    @(negedge clk);
    n_total++; if (o_frm_ok !== 1'b0 || o_rx_cnt !== 32'd0) $display("FAIL inorder_early: got ok=%0b rx=%0d want 0 0", o_frm_ok, o_rx_cnt); else n_pass++;
    @(negedge clk);
    n_total++; if (o_frm_ok !== 1'b1 || o_rx_cnt !== 32'd1) $display("FAIL inorder_latency: got ok=%0b rx=%0d want 1 1", o_frm_ok, o_rx_cnt); else n_pass++;
    @(negedge clk);
    n_total++; if (o_frm_ok !== 1'b0) $display("FAIL inorder_width: got ok=%0b want 0", o_frm_ok); else n_pass++;
    tick();
    frame(8'd6, 32'd1, 7, 1'b1);
    frame(8'd6, 32'd2, 7, 1'b1);
    n_total++; if (n_ok - ok0 !== 3) $display("FAIL inorder_pulses: got %0d want 3", n_ok - ok0); else n_pass++;
    n_total++; if (o_rx_cnt !== 32'd3) $display("FAIL inorder_rx: got %0d want 3", o_rx_cnt); else n_pass++;
    n_total++; if (o_lost_cnt !== 32'd0 || o_err_cnt !== 32'd0) $display("FAIL inorder_lost_err: got lost=%0d err=%0d want 0 0", o_lost_cnt, o_err_cnt); else n_pass++;
    n_total++; if (o_last_seq !== 32'd2 || o_sync !== 1'b1) $display("FAIL inorder_seq_sync: got seq=%0d sync=%0b want 2 1", o_last_seq, o_sync); else n_pass++;
  endtask

  task automatic test_gap();
    int e0;
    do_reset();
    frame(8'd6, 32'd5, 7, 1'b1);
    frame(8'd6, 32'd9, 7, 1'b1);
    n_total++; if (o_rx_cnt !== 32'd2 || o_lost_cnt !== 32'd3) $display("FAIL gap_counts: got rx=%0d lost=%0d want 2 3", o_rx_cnt, o_lost_cnt); else n_pass++;
    e0 = n_err;
    frame(8'd6, 32'd4, 7, 1'b1);
    n_total++; if (n_err - e0 !== 1 || o_err_cnt !== 32'd1) $display("FAIL ooo_err: got pulses=%0d err=%0d want 1 1", n_err - e0, o_err_cnt); else n_pass++;
    n_total++; if (o_last_seq !== 32'd4 || o_rx_cnt !== 32'd2) $display("FAIL ooo_resync: got seq=%0d rx=%0d want 4 2", o_last_seq, o_rx_cnt); else n_pass++;
    frame(8'd6, 32'd5, 7, 1'b1);
    n_total++; if (o_rx_cnt !== 32'd3 || o_lost_cnt !== 32'd3 || o_err_cnt !== 32'd1)
      $display("FAIL after_resync: got rx=%0d lost=%0d err=%0d want 3 3 1", o_rx_cnt, o_lost_cnt, o_err_cnt); else n_pass++;
  endtask

  task automatic test_bad_frames();
    int e0;
    do_reset();
    frame(8'd6, 32'd1, 7, 1'b1);
    e0 = n_err;
    frame(8'd7, 32'd2, 7, 1'b1);
    n_total++; if (n_err - e0 !== 1 || o_err_cnt !== 32'd1 || o_rx_cnt !== 32'd1)
      $display("FAIL bad_length: got pulses=%0d err=%0d rx=%0d want 1 1 1", n_err - e0, o_err_cnt, o_rx_cnt); else n_pass++;
    frame(8'd6, 32'd2, 4, 1'b1);
    n_total++; if (n_err - e0 !== 2 || o_err_cnt !== 32'd2 || o_rx_cnt !== 32'd1)
      $display("FAIL truncated: got pulses=%0d err=%0d rx=%0d want 2 2 1", n_err - e0, o_err_cnt, o_rx_cnt); else n_pass++;
  endtask

  task automatic test_fcs();
    int ok0, e0;
    logic [31:0] exp_rx, exp_err;
    exp_rx  = FCS_EN ? 32'd0 : 32'd1;
    exp_err = FCS_EN ? 32'd1 : 32'd0;
    do_reset();
    ok0 = n_ok; e0 = n_err;
    frame(8'd6, 32'd10, 7, 1'b0);
    n_total++; if (o_rx_cnt !== exp_rx || o_err_cnt !== exp_err)
      $display("FAIL fcs_counts: got rx=%0d err=%0d want %0d %0d", o_rx_cnt, o_err_cnt, exp_rx, exp_err); else n_pass++;
    n_total++; if (n_ok - ok0 !== int'(exp_rx) || n_err - e0 !== int'(exp_err))
      $display("FAIL fcs_pulses: got ok=%0d err=%0d want %0d %0d", n_ok - ok0, n_err - e0, exp_rx, exp_err); else n_pass++;
  endtask

  task automatic test_timeout();
    int waited, e0;
    bit seen;
    waited = 0; seen = 0;
    do_reset();
    e0 = n_err;
    pulse_sfd();
    send_byte(8'd6);
    send_byte(8'h01);
    for (int k = 1; k <= int'(TMO) + 20; k++) begin
      @(negedge clk);
      if (o_frm_err) begin waited = k; seen = 1; break; end
    end
    tick();
    n_total++; if (!seen) $display("FAIL timeout_seen: got no pulse in %0d cycles, want pulse", TMO + 20); else n_pass++;
    n_total++; if (waited < int'(TMO) - 1 || waited > int'(TMO) + 1) $display("FAIL timeout_delay: got %0d want %0d", waited, TMO); else n_pass++;
    n_total++; if (o_err_cnt !== 32'd1) $display("FAIL timeout_err: got %0d want 1", o_err_cnt); else n_pass++;
    end_frame(1'b1);                    // in IDLE: ignored
    tick(); tick();
    n_total++; if (n_err - e0 !== 1 || o_rx_cnt !== 32'd0 || o_err_cnt !== 32'd1)
      $display("FAIL timeout_idle: got pulses=%0d rx=%0d err=%0d want 1 0 1", n_err - e0, o_rx_cnt, o_err_cnt); else n_pass++;
  endtask

  task automatic test_sfd_abort();
    int ok0, e0;
    do_reset();
    ok0 = n_ok; e0 = n_err;
    pulse_sfd();
    send_body(8'd6, 32'h0000_0A03, 3);
    pulse_sfd();                        // abort, restart RECV
    send_body(8'd6, 32'd3, 7);
    end_frame(1'b1);
    tick(); tick(); tick();
    n_total++; if (n_err - e0 !== 1 || o_err_cnt !== 32'd1) $display("FAIL abort_err: got pulses=%0d err=%0d want 1 1", n_err - e0, o_err_cnt); else n_pass++;
    n_total++; if (n_ok - ok0 !== 1 || o_rx_cnt !== 32'd1 || o_last_seq !== 32'd3)
      $display("FAIL abort_next: got pulses=%0d rx=%0d seq=%0d want 1 1 3", n_ok - ok0, o_rx_cnt, o_last_seq); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int ok0, e0;
    do_reset();
    frame(8'd6, 32'd7, 7, 1'b1);
    frame(8'd7, 32'd8, 7, 1'b1);        // leaves err_cnt = 1
    pulse_sfd();
    send_body(8'd6, 32'd8, 3);
    #3 reset = 1;
    #1;
    n_total++; if (o_rx_cnt !== 32'd0 || o_err_cnt !== 32'd0 || o_lost_cnt !== 32'd0)
      $display("FAIL midreset_cnt: got rx=%0d err=%0d lost=%0d want 0", o_rx_cnt, o_err_cnt, o_lost_cnt); else n_pass++;
    n_total++; if (o_sync !== 1'b0 || o_last_seq !== 32'd0 || o_frm_ok !== 1'b0 || o_frm_err !== 1'b0)
      $display("FAIL midreset_state: got sync=%0b seq=%0d ok=%0b err=%0b want 0", o_sync, o_last_seq, o_frm_ok, o_frm_err); else n_pass++;
    ok0 = n_ok; e0 = n_err;
    tick(); reset = 0; tick();
    send_body(8'd6, 32'd8, 4);          // remainder of frame: ignored
    end_frame(1'b1);
    tick(); tick(); tick();
    n_total++; if (n_ok - ok0 !== 0 || n_err - e0 !== 0 || o_rx_cnt !== 32'd0)
      $display("FAIL midreset_quiet: got ok=%0d err=%0d rx=%0d want 0 0 0", n_ok - ok0, n_err - e0, o_rx_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ok0;
    do_reset();
    ok0 = n_ok;
    pulse_sfd();
    send_body(8'd6, 32'd100, 7);
    i_end = 1; tick(); i_end = 0;
    i_sfd = 1; tick(); i_sfd = 0;       // SFD in the CHECK cycle
    send_body(8'd6, 32'd101, 7);
    end_frame(1'b1);
    tick(); tick(); tick();
    n_total++; if (n_ok - ok0 !== 2 || o_rx_cnt !== 32'd2) $display("FAIL b2b_rx: got pulses=%0d rx=%0d want 2 2", n_ok - ok0, o_rx_cnt); else n_pass++;
    n_total++; if (o_last_seq !== 32'd101 || o_lost_cnt !== 32'd0 || o_err_cnt !== 32'd0)
      $display("FAIL b2b_seq: got seq=%0d lost=%0d err=%0d want 101 0 0", o_last_seq, o_lost_cnt, o_err_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    frame(8'd6, 32'hFFFF_FFFF, 7, 1'b1);
    n_total++; if (o_last_seq !== 32'hFFFF_FFFF) $display("FAIL wrap_first: got %0h want ffffffff", o_last_seq); else n_pass++;
    frame(8'd6, 32'd0, 7, 1'b1);
    n_total++; if (o_rx_cnt !== 32'd2 || o_lost_cnt !== 32'd0 || o_err_cnt !== 32'd0 || o_last_seq !== 32'd0)
      $display("FAIL wrap_second: got rx=%0d lost=%0d err=%0d seq=%0h want 2 0 0 0", o_rx_cnt, o_lost_cnt, o_err_cnt, o_last_seq); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_gap();
    test_bad_frames();
    test_fcs();
    test_timeout();
    test_sfd_abort();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_loop.md
# rx_loop

Receive-side loopback checker for the VLC link test setup. It sits behind the receiver core and consumes the per-frame byte stream produced by the looping transmitter test application. Each frame carries a length byte of 6, a 4-byte little-endian frame sequence number and a 2-byte FCS. The block validates each frame, tracks the sequence number, and keeps good, lost and error statistics for readout or for LEDs and a logic analyser.

## Interface
- `TIMEOUT_CNT`, default 32'd2000: maximum idle clocks between bytes inside a frame before the frame is aborted.
- `clk` in 1: single system clock (20 MHz nominal).
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `i_sfd` in 1: one-cycle pulse, start-of-frame delimiter detected.
- `i_byte_valid` in 1: one-cycle strobe, `i_byte` holds a received byte.
- `i_byte` in 8: received byte. Order is length, seq[7:0], seq[15:8], seq[23:16], seq[31:24], FCS0, FCS1.
- `i_end` in 1: one-cycle pulse, frame ended. Never coincident with `i_byte_valid`.
- `i_fcs_ok` in 1: FCS verdict, valid in the `i_end` cycle.
- `o_sync` out 1: high once the first good frame has been accepted.
- `o_frm_ok` out 1: one-cycle pulse, good frame accepted.
- `o_frm_err` out 1: one-cycle pulse, frame rejected.
- `o_last_seq` out 32: sequence number of the last good frame.
- `o_rx_cnt` out 32: good frames. Saturates at 32'hFFFFFFFF.
- `o_lost_cnt` out 32: frames missed according to sequence gaps. Saturates.
- `o_err_cnt` out 32: rejected and out-of-order frames. Saturates.

Every output resets to 0.

## Operation
- State machine `IDLE`, `RECV`, `CHECK`. The reset state is `IDLE`.
- **`IDLE`**
  - `i_sfd` moves to `RECV` and clears the byte index, timeout counter and bad flag.
  - Bytes and `i_end` are ignored.
- **`RECV`**
  - Each `i_byte_valid` stores the byte by index and increments the 3-bit byte index, saturating at 7.
  - Index 0 is the length byte. A value other than 8'd6 sets the bad flag.
  - Indices 1-4 assemble the sequence number, LSB first.
  - Indices 5-6 (FCS) are counted and not stored.
  - A byte arriving at index 7 (overlong frame) sets the bad flag.
  - `i_end` moves to `CHECK` and latches `i_fcs_ok`.
  - `i_sfd` aborts the frame: error pulse, `o_err_cnt`+1, restart `RECV` with cleared index.
  - The timeout counter clears on every byte. Reaching `TIMEOUT_CNT` gives an error pulse, `o_err_cnt`+1, and a move to `IDLE`.
- **`CHECK`** (one cycle) decides the frame:
  - **Bad:** bad flag set, fewer than 7 bytes received, or FCS failed (see Configuration). Result: `o_frm_err` and `o_err_cnt`+1.
  - **First good frame, `o_sync`=0:** accept. Set `o_sync`, load `o_last_seq`, set expected = seq+1.
  - **`seq` == expected:** accept.
  - **`seq` > expected (unsigned):** accept. Add seq−expected to `o_lost_cnt` with a saturating 33-bit add.
  - **`seq` < expected:** counts as out-of-order. Result: `o_frm_err`, `o_err_cnt`+1, resync `o_last_seq`=seq and expected=seq+1.
  - **Any accept:** `o_frm_ok`, `o_rx_cnt`+1, `o_last_seq`=seq, expected=seq+1. Expected wraps from 32'hFFFFFFFF to 0 with no loss counted.
  - **Exit:** to `IDLE`, or to `RECV` if `i_sfd` is asserted in the `CHECK` cycle.
- Counters never wrap. Once a counter reaches all-ones it holds.

## Timing
- `i_end` is sampled at edge N. `CHECK` is active in the following cycle.
- Pulses and counter updates are registered at edge N+1. They are visible in the second cycle after the `i_end` cycle.
- `o_frm_ok` and `o_frm_err` are exclusive and exactly one cycle wide. At most one pulse occurs per frame or abort.
- A timeout or SFD abort pulses `o_frm_err` in the cycle after the triggering edge.
- Back-to-back frames are supported with `i_sfd` as early as the `CHECK` cycle.
- An asynchronous `reset` at any time returns to `IDLE` immediately, with every output at 0. No pulse is emitted for the interrupted frame.

## Configuration
- Macro `RX_LOOP_CONF_FCS_CHECK_EN`.
- **Defined:** a frame with `i_fcs_ok`=0 at `i_end` is bad.
- **Not defined:** `i_fcs_ok` is ignored. Frames are judged on length, byte count and sequence only, for bring-up with an unverified FCS path.

## Test plan
- **In-order frames:** seq 0, 1, 2, each with length 6 and `i_fcs_ok`=1 → three `o_frm_ok` pulses, `o_rx_cnt`=3, `o_lost_cnt`=0, `o_last_seq`=2, `o_sync`=1.
- **Sequence gap:** seq 5 then seq 9 → `o_rx_cnt`=2, `o_lost_cnt`=3. Then seq 4 → `o_frm_err`, `o_err_cnt`=1, `o_last_seq`=4.
- **Bad length:** length byte 8'd7 → `o_frm_err`, `o_err_cnt`+1, `o_rx_cnt` unchanged.
- **Truncated frame:** `i_end` after 4 bytes → `o_frm_err`, `o_err_cnt`+1.
- **FCS failure:** `i_fcs_ok`=0 with the macro defined → `o_err_cnt`+1. Without the macro → `o_frm_ok`.
- **Aborts and reset:**
  - A byte stall of `TIMEOUT_CNT` cycles → `o_err_cnt`+1 and a return to `IDLE`.
  - SFD at mid-frame byte 3, followed by a full frame → `o_err_cnt`+1, then `o_rx_cnt`+1.
  - `reset` pulsed mid-frame → all outputs 0 and no pulses.
- **Wrap:** seq 32'hFFFFFFFF then seq 0 → `o_lost_cnt`=0, both frames accepted.
